// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises a raw switch/button level, samples it on a
// slow free-running tick and only passes a level change once it has stayed
// constant for STABLE_TICKS consecutive ticks.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous reset, active-high
//   sw_in       raw asynchronous switch/button level
//   sw_db       debounced level (registered)
//   busy        high while a candidate change is being qualified (registered)
//   glitch_cnt  saturating count of aborted qualifications (8 bits)
//               -- present only when SWITCH_DEBOUNCER_GLITCH_CNT_EN is defined
module switch_debouncer #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned STABLE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_in,
    output logic       sw_db,
    output logic       busy
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SW  = $clog2(STABLE_TICKS + 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_t;

    logic          sw_s1;
    logic          sw_s2;
    logic          sync;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_nxt;
    state_t        state;
    state_t        state_nxt;

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= 1'b0;
            sw_s2 <= 1'b0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

    assign sync = sw_s2;

    // Free-running sample tick, never restarted by the FSM
    assign tick = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // State, stability counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOW;
            stab_cnt <= '0;
            sw_db    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            sw_db    <= (state_nxt == ST_HIGH) || (state_nxt == ST_FALL_WAIT);
            busy     <= (state_nxt == ST_RISE_WAIT) || (state_nxt == ST_FALL_WAIT);
        end
    end

    // Next-state logic; a reverting sync is checked before the tick so an
    // abort in a tick cycle wins and that tick is not counted
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        case (state)
            ST_LOW: begin
                if (sync) begin
                    state_nxt = ST_RISE_WAIT;
                    stab_nxt  = '0;
                end
            end
            ST_RISE_WAIT: begin
                if (!sync) begin
                    state_nxt = ST_LOW;
                end else if (tick) begin
                    if (stab_cnt == SW'(STABLE_TICKS - 1)) begin
                        state_nxt = ST_HIGH;
                    end else begin
                        stab_nxt = stab_cnt + SW'(1);
                    end
                end
            end
            ST_HIGH: begin
                if (!sync) begin
                    state_nxt = ST_FALL_WAIT;
                    stab_nxt  = '0;
                end
            end
            ST_FALL_WAIT: begin
                if (sync) begin
                    state_nxt = ST_HIGH;
                end else if (tick) begin
                    if (stab_cnt == SW'(STABLE_TICKS - 1)) begin
                        state_nxt = ST_LOW;
                    end else begin
                        stab_nxt = stab_cnt + SW'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_LOW;
                stab_nxt  = '0;
            end
        endcase
    end

`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    logic abort;

    // A WAIT state falling back to its origin is a rejected glitch
    assign abort = ((state == ST_RISE_WAIT) && !sync) ||
                   ((state == ST_FALL_WAIT) &&  sync);

    // Saturating aborted-qualification counter
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_cnt <= 8'd0;
        end else if (abort && (glitch_cnt != 8'hFF)) begin
            glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (DIV=10, STABLE_TICKS=4).
module tb_switch_debouncer;

    logic clk;
    logic rst;
    logic sw_in;
    logic sw_db;
    logic busy;
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int checks    = 0;
    int failures  = 0;
    int tc        = 0;  // expected tick_cnt value after the latest edge
    int exp_glitch = 0;

    switch_debouncer #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .STABLE_TICKS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .sw_db     (sw_db),
        .busy      (busy)
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        if (rst) tc = 0;
        else     tc = (tc + 1) % 10;
        #1;
    endtask

    // Steps until sw_db is 1; n = edge index of the rise, -1 on timeout
    task automatic wait_rise(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (sw_db === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_glitch(input string name);
`ifdef SWITCH_DEBOUNCER_GLITCH_CNT_EN
        checks++;
        if (glitch_cnt !== 8'(exp_glitch)) begin
            failures++;
            $display("FAIL %s glitch_cnt got=%0d exp=%0d", name, glitch_cnt, exp_glitch);
        end
`endif
    endtask

    task automatic settle_low();
        sw_in = 1'b0;
        repeat (60) step();
        checks++;
        if (sw_db !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL settle_low sw_db=%b busy=%b exp 0/0", sw_db, busy);
        end
    endtask

    task automatic test_reset();
        int n;
        rst   = 1'b1;
        sw_in = 1'b1;
        repeat (3) step();
        checks++;
        if (sw_db !== 1'b0) begin
            failures++; $display("FAIL reset_sw_db got=%b exp=0", sw_db);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        check_glitch("reset");
        rst = 1'b0;
        wait_rise(60, n);
        checks++;
        if (n < 34 || n > 43) begin
            failures++; $display("FAIL reset_rise_latency got=%0d exp=34..43", n);
        end
    endtask

    task automatic test_clean_press();
        int n;
        int bad;
        settle_low();
        sw_in = 1'b1;
        step(); step();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL press_busy_c2 got=%b exp=0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL press_busy_c3 got=%b exp=1", busy);
        end
        wait_rise(50, n);
        if (n > 0) n = n + 3;
        checks++;
        if (n < 34 || n > 43) begin
            failures++; $display("FAIL press_rise_latency got=%0d exp=34..43", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL press_busy_after got=%b exp=0", busy);
        end
        bad = 0;
        repeat (200) begin
            step();
            if (sw_db !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL press_hold bad_cycles got=%0d exp=0", bad);
        end
    endtask

    task automatic test_release_glitch();
        int saw_busy;
        int bad;
        saw_busy = 0;
        bad      = 0;
        sw_in = 1'b0;
        repeat (5) begin
            step();
            if (busy === 1'b1) saw_busy++;
            if (sw_db !== 1'b1) bad++;
        end
        sw_in = 1'b1;
        repeat (10) begin
            step();
            if (busy === 1'b1) saw_busy++;
            if (sw_db !== 1'b1) bad++;
        end
        checks++;
        if (saw_busy == 0) begin
            failures++; $display("FAIL release_glitch_fall_wait busy_cycles got=0 exp>0");
        end
        checks++;
        if (bad != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release_glitch_hold bad_cycles=%0d busy=%b exp 0/0", bad, busy);
        end
        exp_glitch++;
        check_glitch("release_glitch");
    endtask

    task automatic test_bounce();
        int n;
        int bad;
        int extra;
        settle_low();
        bad = 0;
        // 1-segments at 0,14,28,42 each end in a 0 -> 4 aborted RISE_WAITs;
        // the segment starting at 56 is the final stable level
        for (int i = 0; i < 60; i++) begin
            sw_in = ((i / 7) % 2 == 0);
            step();
            if (sw_db !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL bounce_held_low bad_cycles got=%0d exp=0", bad);
        end
        wait_rise(60, n);
        if (n > 0) n = n + 4;
        checks++;
        if (n < 34 || n > 43) begin
            failures++; $display("FAIL bounce_rise_latency got=%0d exp=34..43", n);
        end
        extra = 0;
        repeat (60) begin
            step();
            if (sw_db !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL bounce_single_edge low_cycles got=%0d exp=0", extra);
        end
        exp_glitch = exp_glitch + 4;
        check_glitch("bounce");
    endtask

    // Press, count ticks while qualifying, stop after `want` counted ticks
    task automatic qualify_ticks(input int want, input string name);
        int ticks;
        int pb;
        int guard;
        sw_in = 1'b1;
        guard = 0;
        while (busy !== 1'b1 && guard < 6) begin
            step(); guard++;
        end
        ticks = 0;
        guard = 0;
        while (ticks < want && guard < 60) begin
            pb = (busy === 1'b1);
            step(); guard++;
            if (pb != 0 && busy === 1'b1 && tc == 0) ticks++;
        end
        checks++;
        if (ticks != want || busy !== 1'b1 || sw_db !== 1'b0) begin
            failures++;
            $display("FAIL %s_setup ticks=%0d busy=%b sw_db=%b exp %0d/1/0",
                     name, ticks, busy, sw_db, want);
        end
    endtask

    task automatic test_collision();
        int bad;
        settle_low();
        qualify_ticks(3, "collision");
        while (tc != 7) step();
        sw_in = 1'b0;
        step(); step();
        checks++;
        if (busy !== 1'b1 || sw_db !== 1'b0) begin
            failures++;
            $display("FAIL collision_pre busy=%b sw_db=%b exp 1/0", busy, sw_db);
        end
        step();  // tick edge coincides with sync back at 0
        checks++;
        if (sw_db !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL collision_abort sw_db=%b busy=%b exp 0/0", sw_db, busy);
        end
        exp_glitch++;
        check_glitch("collision");
        bad = 0;
        repeat (20) begin
            step();
            if (sw_db !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL collision_stay_low bad_cycles got=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_mid_qual();
        int n;
        qualify_ticks(2, "midrst");
        rst = 1'b1;
        step();
        checks++;
        if (sw_db !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs sw_db=%b busy=%b exp 0/0", sw_db, busy);
        end
        exp_glitch = 0;
        check_glitch("midrst");
        rst = 1'b0;
        wait_rise(60, n);
        checks++;
        if (n < 34 || n > 43) begin
            failures++; $display("FAIL midrst_requalify_latency got=%0d exp=34..43", n);
        end
    endtask

    initial begin
        rst   = 1'b1;
        sw_in = 1'b0;
        test_reset();
        test_clean_press();
        test_release_glitch();
        test_bounce();
        test_collision();
        test_reset_mid_qual();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
